// File: rtl/y86_alu_pkg.sv
// y86_alu_pkg: shared Y86-64 ALU encodings and the condition-code flag type.
package y86_alu_pkg;
    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } flags_t;
    localparam flags_t FLAGS_RST = 3'b100;
endpackage

// File: rtl/y86_cond_eval.sv
// y86_cond_eval: combinational jXX/cmovXX condition decode against a flag set.
module y86_cond_eval
    import y86_alu_pkg::*;
(
    input  flags_t     flags,
    input  logic [3:0] ifun,
    output logic       cond,
    output logic       err
);
    logic lt;
    always_comb begin
        lt   = flags.sf ^ flags.of;
        cond = ifun == C_ALWAYS ? 1'b1 :
               ifun == C_LE     ? lt | flags.zf :
               ifun == C_L      ? lt :
               ifun == C_E      ? flags.zf :
               ifun == C_NE     ? !flags.zf :
               ifun == C_GE     ? !lt :
               ifun == C_G      ? !lt && !flags.zf : 1'b0;
        err  = ifun > C_G;
    end
endmodule

// File: rtl/y86_cc_unit.sv
// y86_cc_unit: Y86-64 condition-code register with a registered one-cycle condition verdict.
// Define Y86_CC_FWD_EN to evaluate a same-cycle request against the freshly computed flags.
module y86_cc_unit
    import y86_alu_pkg::*;
#(
    parameter int WIDTH = 64
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             op,
    input  logic [WIDTH-1:0] result,
    input  logic             set_cc,
    input  logic             bubble,
    input  logic             stall,
    input  logic             cond_req,
    input  logic [3:0]       cond_ifun,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             cond_valid,
    output logic             cond_true,
    output logic             cond_err
);
    flags_t flags, flags_n, eval_flags;
    logic   msb1, msb2, msbr, load, req, cond, err;
    logic   unused_bits;
    // Only the sign bits of the operands matter for overflow detection.
    assign unused_bits = ^{in1[WIDTH-2:0], in2[WIDTH-2:0]};
    always_comb begin
        msb1       = in1[WIDTH-1];
        msb2       = in2[WIDTH-1];
        msbr       = result[WIDTH-1];
        flags_n.zf = result == '0;
        flags_n.sf = msbr;
        flags_n.of = (op == OP_SUB ? msb1 != msb2 : msb1 == msb2) && msbr != msb1;
    end
    assign load = set_cc && !bubble;
    assign req  = cond_req && !bubble;
`ifdef Y86_CC_FWD_EN
    assign eval_flags = load ? flags_n : flags;
`else
    assign eval_flags = flags;
`endif
    y86_cond_eval u_eval (
        .flags (eval_flags),
        .ifun  (cond_ifun),
        .cond  (cond),
        .err   (err)
    );
    assign zf = flags.zf;
    assign sf = flags.sf;
    assign of = flags.of;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags      <= FLAGS_RST;
            cond_valid <= 1'b0;
            cond_true  <= 1'b0;
            cond_err   <= 1'b0;
        end else if (!stall) begin
            if (load) flags <= flags_n;
            cond_valid <= req;
            cond_true  <= req && cond;
            cond_err   <= req && err;
        end
    end
endmodule

// File: tb/tb_y86_cc_unit.sv
// tb_y86_cc_unit: randomized scoreboard bench for y86_cc_unit against an arithmetic reference model.
// Honours Y86_CC_FWD_EN the same way the design does.
module tb_y86_cc_unit;
    typedef struct {
        logic [2:0] flg;
        logic       v;
        logic       t;
        logic       e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in1 = '0, in2 = '0, result = '0;
    logic        op = 1'b0, set_cc = 1'b0, bubble = 1'b0, stall = 1'b0, cond_req = 1'b0;
    logic [3:0]  cond_ifun = '0;
    logic        zf, sf, of, cond_valid, cond_true, cond_err;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0, m_v = 1'b0, m_t = 1'b0, m_e = 1'b0;

    y86_cc_unit #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in1(in1), .in2(in2), .op(op), .result(result),
        .set_cc(set_cc), .bubble(bubble), .stall(stall), .cond_req(cond_req),
        .cond_ifun(cond_ifun), .zf(zf), .sf(sf), .of(of),
        .cond_valid(cond_valid), .cond_true(cond_true), .cond_err(cond_err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu(input logic [63:0] a, input logic [63:0] b, input logic o);
        return o ? a - b : a + b;
    endfunction

    // Branch semantics phrased as signed comparisons of the last compared values.
    function automatic logic ref_cond(input logic z, input logic s, input logic o, input logic [3:0] fn);
        logic less;
        less = (s != o);
        case (fn)
            4'd0: return 1'b1;
            4'd1: return less || z;
            4'd2: return less;
            4'd3: return z;
            4'd4: return !z;
            4'd5: return !less;
            4'd6: return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input logic [63:0] a, input logic [63:0] b, input logic o, input logic [63:0] r,
                        input logic sc, input logic bub, input logic stl, input logic rq, input logic [3:0] fn);
        logic signed [64:0] wide;
        logic nz, ns, no, ez, es, eo, fwd;
        exp_t ex;
        @(posedge clk);
        #3;
        rst_n = 1'b1; in1 = a; in2 = b; op = o; result = r;
        set_cc = sc; bubble = bub; stall = stl; cond_req = rq; cond_ifun = fn;
        wide = o ? $signed({a[63], a}) - $signed({b[63], b}) : $signed({a[63], a}) + $signed({b[63], b});
        nz = (r == 64'd0);
        ns = $signed(r) < 0;
        no = wide[64] != wide[63];
        fwd = 1'b0;
`ifdef Y86_CC_FWD_EN
        fwd = sc && !bub;
`endif
        ez = fwd ? nz : m_zf;
        es = fwd ? ns : m_sf;
        eo = fwd ? no : m_of;
        if (!stl) begin
            m_v = rq && !bub;
            m_t = m_v && ref_cond(ez, es, eo, fn);
            m_e = m_v && (fn > 4'd6);
            if (sc && !bub) begin
                m_zf = nz; m_sf = ns; m_of = no;
            end
        end
        ex.flg = {m_zf, m_sf, m_of};
        ex.v = m_v; ex.t = m_t; ex.e = m_e;
        q.push_back(ex);
    endtask

    task automatic idle();
        step(64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic req(input logic [3:0] fn);
        step(64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, fn);
    endtask

    task automatic arith(input logic [63:0] a, input logic [63:0] b, input logic o,
                         input logic sc, input logic bub, input logic stl, input logic rq, input logic [3:0] fn);
        step(a, b, o, alu(a, b, o), sc, bub, stl, rq, fn);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'd1;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    // Monitor: every cycle the DUT presents the state the model predicted for it.
    initial begin
        exp_t ex;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                ex = q.pop_front();
                check("flags", {1'b0, zf, sf, of}, {1'b0, ex.flg});
                check("cond_valid", {3'b0, cond_valid}, {3'b0, ex.v});
                if (ex.v) begin
                    check("cond_true", {3'b0, cond_true}, {3'b0, ex.t});
                    check("cond_err", {3'b0, cond_err}, {3'b0, ex.e});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b;
        repeat (2) @(posedge clk);
        #2;
        check("reset_flags", {1'b0, zf, sf, of}, 4'b0100);
        check("reset_valid", {3'b0, cond_valid}, 4'd0);

        arith(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        req(4'd2);
        req(4'd6);
        arith(64'h1234, 64'h1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        req(4'd1);
        req(4'd4);
        arith(64'd1, 64'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        arith(64'd5, 64'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3);
        req(4'd3);
        arith(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        req(4'd0);
        repeat (3) arith(64'd3, 64'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4);
        repeat (3) arith(64'd3, 64'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9);
        req(4'd9);
        req(4'd0);
        idle();

        // Asynchronous reset lands while a verdict is showing.
        arith(64'd2, 64'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        req(4'd0);
        @(posedge clk);
        #3;
        q.delete();
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", {1'b0, zf, sf, of}, 4'b0100);
        check("async_rst_valid", {3'b0, cond_valid}, 4'd0);
        check("async_rst_true", {3'b0, cond_true}, 4'd0);
        m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_v = 1'b0; m_t = 1'b0; m_e = 1'b0;
        req(4'd3);
        idle();

        for (int i = 0; i < 400; i++) begin
            a = pick();
            b = ($urandom_range(0, 5) == 0) ? a : pick();
            arith(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 6,
                  ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)));
        end
        idle();
        idle();
        @(posedge clk);
        #3;
        check("scoreboard_drained", 4'(q.size()), 4'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/y86_cc_unit.md
Name: y86_cc_unit

Overview:
- Condition-code consumer for the 64-bit add/sub datapath. It sits at the execute-stage output of the Y86-64 pipeline.
- Captures ZF/SF/OF from the add/sub operands and result on set_cc.
- Evaluates Y86 jXX/cmovXX conditions against the stored flags and returns a registered, one-cycle-latency verdict.
- Handles pipeline stall and bubble control.

Parameters:
- WIDTH, 64, datapath width of operands/result; flags derive from bit WIDTH-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in1  in  WIDTH  add/sub operand A, as fed to the adder
- in2  in  WIDTH  add/sub operand B, un-inverted
- op  in  1  0 = add (in1+in2), 1 = sub (in1-in2)
- result  in  WIDTH  add/sub output for in1/in2/op
- set_cc  in  1  capture flags this cycle
- bubble  in  1  squash: suppresses set_cc and cond_req this cycle
- stall  in  1  hold all state and outputs
- cond_req  in  1  request condition evaluation
- cond_ifun  in  4  Y86 ifun code of jXX/cmovXX
- zf, sf, of  out  1 each  registered flags
- cond_valid  out  1  verdict valid (one cycle after cond_req)
- cond_true  out  1  condition satisfied
- cond_err  out  1  cond_ifun > 6 (illegal)

Behaviour:
- Reset (async, rst_n=0):
  - zf=1, sf=0, of=0.
  - cond_valid=0, cond_true=0, cond_err=0.
  - Reset mid-operation discards any pending verdict.
- Flag computation (combinational from inputs):
  - ZF_n = (result==0).
  - SF_n = result[WIDTH-1].
  - OF_n, add: in1[MSB]==in2[MSB] && result[MSB]!=in1[MSB].
  - OF_n, sub: in1[MSB]!=in2[MSB] && result[MSB]!=in1[MSB].
  - Result is not recomputed internally; the unit trusts result.
- Capture: at posedge, if set_cc && !bubble && !stall, the flags load ZF_n/SF_n/OF_n. Otherwise they hold.
- Evaluation, one-cycle latency:
  - At posedge, if !stall: cond_valid <= cond_req && !bubble.
  - cond_true/cond_err are registered from the flags current at request time. Default: pre-update flags, so set_cc in the same cycle does not affect the verdict.
  - If cond_req is low or bubble is high, cond_valid=0 and cond_true=0 next cycle.
- Condition table (ifun: cond):
  - 0: 1
  - 1: (SF^OF)|ZF
  - 2: SF^OF
  - 3: ZF
  - 4: !ZF
  - 5: !(SF^OF)
  - 6: !(SF^OF)&&!ZF
  - 7-15: cond_true=0, cond_err=1.
- Stall: every register holds, including cond_valid. Its verdict stays asserted until the stall releases.
- Stall + bubble together: stall dominates; nothing updates.
- Back-to-back cond_req: one verdict per cycle, fully pipelined, no gaps.

Optional Feature:
- Macro: Y86_CC_FWD_EN.
- Defined: when set_cc && !bubble && cond_req occur in the same cycle, evaluation uses ZF_n/SF_n/OF_n (forwarded new flags).
- Undefined: evaluation always uses the stored flags (pre-update).
- Flag register behaviour is identical in both builds.

Decomposition:
- Package y86_alu_pkg holds:
  - Condition ifun constants C_ALWAYS=0, C_LE=1, C_L=2, C_E=3, C_NE=4, C_GE=5, C_G=6.
  - ALU op constants OP_ADD=0, OP_SUB=1.
  - Packed flag struct {zf,sf,of} with its reset value.
- One sub-module y86_cond_eval (combinational): inputs flag struct + ifun; outputs cond/err. It is reused by the cmov write-enable logic.

Test Plan:
- Reset: assert rst_n=0 mid-stream with cond_valid high -> immediately zf=1, sf=0, of=0, cond_valid=0; a cond_req ifun=3 in the first cycle after release -> cond_true=1 next cycle.
- Signed add overflow: in1=0x7FFF_FFFF_FFFF_FFFF, in2=1, op=0, result=0x8000_0000_0000_0000, set_cc=1 -> next cycle zf=0, sf=1, of=1; then ifun=2 (l) -> cond_true=0, ifun=6 (g) -> cond_true=1.
- Sub equal: in1=in2=0x1234, op=1, result=0, set_cc=1 -> zf=1, sf=0, of=0; ifun=1 -> 1, ifun=4 -> 0.
- Same-cycle set_cc + cond_req ifun=3:
  - Old flags zf=0, new ZF_n=1.
  - Without Y86_CC_FWD_EN: cond_true=0.
  - With it: cond_true=1.
- Bubble/stall/illegal:
  - set_cc=1 with bubble=1 -> flags unchanged, cond_valid=0.
  - stall=1 for 3 cycles -> all outputs frozen.
  - ifun=9 -> cond_valid=1, cond_true=0, cond_err=1.
